c3lib_avmm_pulse_arb: RTL and testbench

//  Round-robin arbiter that shares one pulse clock-crossing channel between NREQ requesters in i_clk domain.

---
 rtl/c3lib_avmm_pulse_arb_if.sv | 65 ++++++
 rtl/c3lib_avmm_pulse_arb.sv | 189 ++++++++++++++++++
 tb/tb_c3lib_avmm_pulse_arb.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c3lib_avmm_pulse_arb_if.sv
// ---------------------------------------------------------------------------
// c3lib_avmm_pulse_arb_if
//   Bundle of request, crossing and status signals shared between the pulse
//   arbiter and its environment (event sources, pulse-crossing primitive and
//   status/clear logic).
//
//   Parameters
//     NREQ : number of requesters
//     IDW  : requester ID width, (NREQ>1) ? $clog2(NREQ) : 1
//
//   Signals (direction as seen by the arbiter, modport slave)
//     i_req         in   NREQ  per-requester request pulse
//     o_pend        out  NREQ  pending request bits
//     i_xfer_ready  in   1     crossing ready for next pulse
//     o_xfer_pulse  out  1     pulse to crossing input
//     o_xfer_id     out  IDW   ID of granted requester
//     o_done        out  1     one-cycle completion strobe
//     o_done_id     out  IDW   ID that completed, valid with o_done
//     o_busy        out  1     arbiter not idle
//     o_timeout     out  1     sticky abort-by-timeout flag
//     i_clr_timeout in   1     clears o_timeout
// ---------------------------------------------------------------------------
interface c3lib_avmm_pulse_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0] i_req;
    logic [NREQ-1:0] o_pend;
    logic            i_xfer_ready;
    logic            o_xfer_pulse;
    logic [IDW-1:0]  o_xfer_id;
    logic            o_done;
    logic [IDW-1:0]  o_done_id;
    logic            o_busy;
    logic            o_timeout;
    logic            i_clr_timeout;

    // Arbiter side.
    modport slave (
        input  i_req,
        input  i_xfer_ready,
        input  i_clr_timeout,
        output o_pend,
        output o_xfer_pulse,
        output o_xfer_id,
        output o_done,
        output o_done_id,
        output o_busy,
        output o_timeout
    );

    // Environment side: event sources, crossing model, status consumer.
    modport master (
        output i_req,
        output i_xfer_ready,
        output i_clr_timeout,
        input  o_pend,
        input  o_xfer_pulse,
        input  o_xfer_id,
        input  o_done,
        input  o_done_id,
        input  o_busy,
        input  o_timeout
    );
endinterface

// File: rtl/c3lib_avmm_pulse_arb.sv
// ---------------------------------------------------------------------------
// c3lib_avmm_pulse_arb
//   Round-robin arbiter sharing one pulse clock-crossing channel between NREQ
//   requesters. Single-cycle request pulses are latched into pending bits;
//   one crossing is issued at a time with a stable ID, and completion is
//   detected as the crossing's ready flag dropping and returning high. A
//   crossing that does not complete within TIMEOUT_CYC cycles is aborted and
//   flagged on the sticky o_timeout output.
//
//   Ports
//     i_clk   : clock
//     i_rstn  : asynchronous active-low reset
//     bus     : c3lib_avmm_pulse_arb_if.slave (requests, crossing handshake,
//               completion and status)
//
//   Parameters
//     NREQ        : number of requesters (>=1)
//     TIMEOUT_CYC : cycles allowed in WAIT_LO+WAIT_HI before abort, 0 = off
//     CNTW        : timeout counter width, 2**CNTW > TIMEOUT_CYC
// ---------------------------------------------------------------------------
module c3lib_avmm_pulse_arb #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNTW        = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    c3lib_avmm_pulse_arb_if.slave    bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // NREQ expressed one bit wider than an ID so ptr+1+offset never overflows.
    localparam logic [IDW:0]    NREQ_W    = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]  PTR_RST   = IDW'(NREQ - 1);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(TIMEOUT_CYC - 1);
    localparam bit              TO_ENABLE = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_WAIT_HI = 2'd3
    } state_t;

    state_t          state_reg;
    logic [NREQ-1:0] pend_reg;
    logic [NREQ-1:0] pend_next;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  id_reg;
    logic            pulse_reg;
    logic            done_reg;
    logic [IDW-1:0]  done_id_reg;
    logic            busy_reg;
    logic            timeout_reg;
    logic [CNTW-1:0] cnt_reg;

    // ------------------------------------------------------------------
    // Round-robin candidate order: cand_idx[gi] is the requester examined
    // gi-th, starting just after the last winner and wrapping mod NREQ.
    // ------------------------------------------------------------------
    logic [IDW-1:0] cand_idx [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum          = {1'b0, ptr_reg} + (IDW+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= NREQ_W) ? IDW'(sum - NREQ_W)
                                                  : sum[IDW-1:0];
        end
    endgenerate

    logic           win_found;
    logic [IDW-1:0] win_idx;

    // Scan from the last candidate down so the earliest one in RR order
    // is the final assignment and therefore wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (pend_reg[cand_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    logic            grant_now;
    logic [NREQ-1:0] grant_mask;

    assign grant_now  = (state_reg == ST_IDLE) && win_found;
    assign grant_mask = grant_now ? (NREQ'(1) << win_idx) : '0;

    // A request arriving in the grant cycle re-sets the bit, so it is
    // served again later instead of being merged into the current grant.
    assign pend_next  = (pend_reg & ~grant_mask) | bus.i_req;

    logic timeout_hit;
    assign timeout_hit = TO_ENABLE && (cnt_reg == CNT_LAST);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg   <= ST_IDLE;
            pend_reg    <= '0;
            ptr_reg     <= PTR_RST;
            id_reg      <= '0;
            pulse_reg   <= 1'b0;
            done_reg    <= 1'b0;
            done_id_reg <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            pend_reg <= pend_next;
            done_reg <= 1'b0;

            // Clear first; an abort below in the same cycle overrides it.
            if (bus.i_clr_timeout) begin
                timeout_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    // Ready level is deliberately not looked at here.
                    if (win_found) begin
                        id_reg    <= win_idx;
                        ptr_reg   <= win_idx;
                        pulse_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // Pulse is held until the crossing takes it; no timeout.
                    if (bus.i_xfer_ready) begin
                        pulse_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT_LO;
                    end
                end

                ST_WAIT_LO: begin
                    cnt_reg <= cnt_reg + CNTW'(1);
                    if (!bus.i_xfer_ready) begin
                        state_reg <= ST_WAIT_HI;
                    end else if (timeout_hit) begin
                        busy_reg    <= 1'b0;
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end

                ST_WAIT_HI: begin
                    cnt_reg <= cnt_reg + CNTW'(1);
                    if (bus.i_xfer_ready) begin
                        done_reg    <= 1'b1;
                        done_id_reg <= id_reg;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end else if (timeout_hit) begin
                        // Aborted crossing is dropped, not re-queued.
                        busy_reg    <= 1'b0;
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end

                default: begin
                    pulse_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_pend       = pend_reg;
    assign bus.o_xfer_pulse = pulse_reg;
    assign bus.o_xfer_id    = id_reg;
    assign bus.o_done       = done_reg;
    assign bus.o_done_id    = done_id_reg;
    assign bus.o_busy       = busy_reg;
    assign bus.o_timeout    = timeout_reg;

endmodule

// File: tb/tb_c3lib_avmm_pulse_arb.sv
// ---------------------------------------------------------------------------
// tb_c3lib_avmm_pulse_arb
//   Self-checking bench for the round-robin pulse arbiter. Expected grant and
//   completion IDs are queued when requests are driven and compared when the
//   arbiter issues a pulse or strobes o_done.
// ---------------------------------------------------------------------------
module tb_c3lib_avmm_pulse_arb;
    localparam int NREQ = 4;
    localparam int TO   = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    c3lib_avmm_pulse_arb_if #(.NREQ(NREQ)) bus();

    c3lib_avmm_pulse_arb #(
        .NREQ        (NREQ),
        .TIMEOUT_CYC (TO),
        .CNTW        (8)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int grant_q[$];
    int done_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn              = 1'b0;
        bus.i_req         = '0;
        bus.i_xfer_ready  = 1'b1;
        bus.i_clr_timeout = 1'b0;
        grant_q.delete();
        done_q.delete();
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic pulse_req(input logic [NREQ-1:0] r);
        bus.i_req = r;
        step();
        bus.i_req = '0;
    endtask

    task automatic push_xfer(input int id);
        grant_q.push_back(id);
        done_q.push_back(id);
    endtask

    // Wait (bounded) for a pulse and compare its ID with the next expected grant.
    task automatic expect_issue(input string name);
        int n = 0;
        int exp;
        while (bus.o_xfer_pulse !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (bus.o_xfer_pulse !== 1'b1) begin
            errors++;
            $display("FAIL %s issue: o_xfer_pulse=%b required 1", name, bus.o_xfer_pulse);
        end else if (grant_q.size() == 0) begin
            errors++;
            $display("FAIL %s issue: unexpected grant id=%0d required none", name, bus.o_xfer_id);
        end else begin
            exp = grant_q.pop_front();
            if (bus.o_xfer_id !== 2'(exp)) begin
                errors++;
                $display("FAIL %s grant: o_xfer_id=%0d required %0d", name, bus.o_xfer_id, exp);
            end else begin
                $display("grant   %s id=%0d t=%0t", name, bus.o_xfer_id, $time);
            end
        end
    endtask

    // From WAIT_LO: hold ready low for lo cycles, raise it, check completion.
    task automatic finish_crossing(input int lo, input string name);
        int n = 0;
        int exp;
        bus.i_xfer_ready = 1'b0;
        repeat (lo) step();
        bus.i_xfer_ready = 1'b1;
        step();
        while (bus.o_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (bus.o_done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: o_done=%b required 1", name, bus.o_done);
        end else if (done_q.size() == 0) begin
            errors++;
            $display("FAIL %s done: unexpected done id=%0d required none", name, bus.o_done_id);
        end else begin
            exp = done_q.pop_front();
            if (bus.o_done_id !== 2'(exp) || bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL %s done: o_done_id=%0d o_busy=%b required %0d 0",
                         name, bus.o_done_id, bus.o_busy, exp);
            end else begin
                $display("done    %s id=%0d t=%0t", name, bus.o_done_id, $time);
            end
        end
    endtask

    // From ISSUE with ready high: accept edge, then complete.
    task automatic run_crossing(input int lo, input string name);
        step();
        checks++;
        if (bus.o_xfer_pulse !== 1'b0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: pulse=%b busy=%b required 0 1",
                     name, bus.o_xfer_pulse, bus.o_busy);
        end
        finish_crossing(lo, name);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (bus.o_pend !== '0 || bus.o_xfer_pulse !== 1'b0 || bus.o_xfer_id !== '0 ||
            bus.o_done !== 1'b0 || bus.o_done_id !== '0 || bus.o_busy !== 1'b0 ||
            bus.o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s: pend=%b pulse=%b id=%0d done=%b done_id=%0d busy=%b to=%b required all 0",
                     name, bus.o_pend, bus.o_xfer_pulse, bus.o_xfer_id, bus.o_done,
                     bus.o_done_id, bus.o_busy, bus.o_timeout);
        end else begin
            $display("reset   %s outputs zero t=%0t", name, $time);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_all_zero("reset_state");
    endtask

    task automatic test_single();
        do_reset();
        push_xfer(2);
        pulse_req(4'b0100);
        checks++;
        if (bus.o_pend !== 4'b0100 || bus.o_xfer_pulse !== 1'b0) begin
            errors++;
            $display("FAIL single_pend: pend=%b pulse=%b required 0100 0", bus.o_pend, bus.o_xfer_pulse);
        end
        step();
        checks++;
        if (bus.o_xfer_pulse !== 1'b1 || bus.o_pend !== 4'b0000 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: pulse=%b pend=%b busy=%b required 1 0000 1",
                     bus.o_xfer_pulse, bus.o_pend, bus.o_busy);
        end
        expect_issue("single");
        run_crossing(5, "single");
    endtask

    task automatic test_round_robin();
        do_reset();
        push_xfer(0);
        push_xfer(1);
        push_xfer(3);
        pulse_req(4'b1011);
        for (int i = 0; i < 3; i++) begin
            expect_issue("rr_1011");
            run_crossing(1, "rr_1011");
        end
        push_xfer(0);
        push_xfer(3);
        pulse_req(4'b1001);
        for (int i = 0; i < 2; i++) begin
            expect_issue("rr_1001");
            run_crossing(1, "rr_1001");
        end
        push_xfer(3);
        push_xfer(0);
        pulse_req(4'b1000);
        expect_issue("rr_3then0");
        // Request 0 arrives on the accept edge of requester 3's crossing.
        pulse_req(4'b0001);
        finish_crossing(1, "rr_3then0");
        expect_issue("rr_3then0");
        run_crossing(1, "rr_3then0");
    endtask

    task automatic test_issue_hold();
        do_reset();
        bus.i_xfer_ready = 1'b0;
        push_xfer(0);
        pulse_req(4'b0001);
        expect_issue("hold");
        for (int i = 2; i <= 7; i++) begin
            step();
            checks++;
            if (bus.o_xfer_pulse !== 1'b1 || bus.o_timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: pulse=%b timeout=%b required 1 0",
                         i, bus.o_xfer_pulse, bus.o_timeout);
            end
        end
        bus.i_xfer_ready = 1'b1;
        step();
        checks++;
        if (bus.o_xfer_pulse !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: pulse=%b required 0", bus.o_xfer_pulse);
        end
        finish_crossing(2, "hold");
        checks++;
        if (bus.o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_timeout: timeout=%b required 0", bus.o_timeout);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        grant_q.push_back(2);
        pulse_req(4'b0100);
        expect_issue("timeout");
        step();
        bus.i_xfer_ready = 1'b0;
        for (int i = 1; i <= TO - 1; i++) begin
            step();
            checks++;
            if (bus.o_busy !== 1'b1 || bus.o_timeout !== 1'b0 || bus.o_done !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: busy=%b timeout=%b done=%b required 1 0 0",
                         i, bus.o_busy, bus.o_timeout, bus.o_done);
            end
        end
        step();
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_timeout !== 1'b1 || bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: busy=%b timeout=%b done=%b required 0 1 0",
                     bus.o_busy, bus.o_timeout, bus.o_done);
        end else begin
            $display("abort   timeout id=2 t=%0t", $time);
        end
        repeat (3) begin
            step();
            checks++;
            if (bus.o_done !== 1'b0 || bus.o_timeout !== 1'b1 || bus.o_xfer_pulse !== 1'b0) begin
                errors++;
                $display("FAIL timeout_sticky: done=%b timeout=%b pulse=%b required 0 1 0",
                         bus.o_done, bus.o_timeout, bus.o_xfer_pulse);
            end
        end
        bus.i_clr_timeout = 1'b1;
        step();
        bus.i_clr_timeout = 1'b0;
        checks++;
        if (bus.o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: timeout=%b required 0", bus.o_timeout);
        end
        bus.i_xfer_ready = 1'b1;
        push_xfer(1);
        pulse_req(4'b0010);
        expect_issue("after_timeout");
        run_crossing(3, "after_timeout");
    endtask

    task automatic test_requeue();
        do_reset();
        push_xfer(1);
        push_xfer(1);
        bus.i_req = 4'b0010;
        step();
        step();
        bus.i_req = '0;
        checks++;
        if (bus.o_pend !== 4'b0010 || bus.o_xfer_pulse !== 1'b1) begin
            errors++;
            $display("FAIL requeue_pend: pend=%b pulse=%b required 0010 1", bus.o_pend, bus.o_xfer_pulse);
        end
        expect_issue("requeue");
        run_crossing(1, "requeue");
        expect_issue("requeue");
        run_crossing(1, "requeue");
        checks++;
        if (bus.o_pend !== 4'b0000) begin
            errors++;
            $display("FAIL requeue_empty: pend=%b required 0000", bus.o_pend);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        grant_q.push_back(1);
        pulse_req(4'b0010);
        expect_issue("reset_mid");
        pulse_req(4'b1100);
        bus.i_xfer_ready = 1'b0;
        step();
        checks++;
        if (bus.o_pend !== 4'b1100 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: pend=%b busy=%b required 1100 1", bus.o_pend, bus.o_busy);
        end
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("reset_mid_async");
        step();
        rstn             = 1'b1;
        bus.i_xfer_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bus.o_busy !== 1'b0 || bus.o_xfer_pulse !== 1'b0 || bus.o_pend !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_idle%0d: busy=%b pulse=%b pend=%b required 0 0 0000",
                         i, bus.o_busy, bus.o_xfer_pulse, bus.o_pend);
            end
        end
        push_xfer(0);
        pulse_req(4'b0001);
        expect_issue("post_reset");
        run_crossing(1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_issue_hold();
        test_timeout();
        test_requeue();
        test_reset_mid();
        checks++;
        if (grant_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: grants_left=%0d dones_left=%0d required 0 0",
                     grant_q.size(), done_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
